// File: rtl/rca_p_pkg.sv
// rca_p_pkg: shared constants for the ripple-carry adder slice
package rca_p_pkg;
    localparam int DEFAULT_N = 4;
endpackage

// File: rtl/rca_p_fa.sv
// rca_p_fa: 1-bit full adder cell used as one stage of the ripple chain
module rca_p_fa (
    input  logic A,
    input  logic B,
    input  logic CIN,
    output logic S,
    output logic COUT
);
    assign S    = A ^ B ^ CIN;
    assign COUT = (A & B) | (A & CIN) | (B & CIN);
endmodule

// File: rtl/rca_p.sv
// rca_p: N-bit ripple-carry adder with a registered {COUT,SUM} result
module rca_p
    import rca_p_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [N:1] A,
    input  logic [N:1] B,
    input  logic       CIN,
    output logic [N:1] SUM,
    output logic       COUT
);
    logic [N:0] c;
    logic [N:1] s;
    assign c[0] = CIN;
    genvar i;
    for (i = 1; i <= N; i++) begin : g_fa
        rca_p_fa u_fa (
            .A   (A[i]),
            .B   (B[i]),
            .CIN (c[i-1]),
            .S   (s[i]),
            .COUT(c[i])
        );
    end
    // result register; reset is sampled only at the clock edge
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            SUM  <= '0;
            COUT <= 1'b0;
        end else begin
            SUM  <= s;
            COUT <= c[N];
        end
    end
endmodule

// File: tb/tb_rca_p.sv
// tb_rca_p: scoreboard bench for the registered ripple-carry adder (N=4)
module tb_rca_p;
    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [4:1] A = '0;
    logic [4:1] B = '0;
    logic       CIN = 1'b0;
    logic [4:1] SUM;
    logic       COUT;
    logic [4:0] sb[$];
    logic [4:0] exp_v;
    int nvec = 0;
    int nerr = 0;

    rca_p #(.N(4)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .A    (A),
        .B    (B),
        .CIN  (CIN),
        .SUM  (SUM),
        .COUT (COUT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic rn);
        @(negedge CLK);
        A = a; B = b; CIN = ci; RST_N = rn;
        sb.push_back(rn ? ({1'b0, a} + {1'b0, b} + {4'b0, ci}) : 5'd0);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            step(4'hF, 4'hF, 1'b1, 1'b0);
            exp_v = sb.pop_front();
            nvec++;
            if ({COUT, SUM} !== exp_v) begin
                nerr++;
                $display("FAIL reset[%0d] got=%b exp=%b", k, {COUT, SUM}, exp_v);
            end
        end
    endtask

    task automatic test_directed();
        logic [8:0] tbl[5];
        logic [4:0] req[5];
        tbl = '{9'b0_0000_0000, 9'b0_1100_0011, 9'b1_1100_1011, 9'b1_0100_0011, 9'b1_1111_1111};
        req = '{5'b0_0000, 5'b0_1111, 5'b1_1000, 5'b0_1000, 5'b1_1111};
        for (int k = 0; k < 5; k++) begin
            step(tbl[k][3:0], tbl[k][7:4], tbl[k][8], 1'b1);
            exp_v = sb.pop_front();
            nvec++;
            if ({COUT, SUM} !== exp_v || exp_v !== req[k]) begin
                nerr++;
                $display("FAIL directed[%0d] got=%b exp=%b req=%b", k, {COUT, SUM}, exp_v, req[k]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge CLK);
        RST_N = 1'b0;
        #2;
        nvec++;
        if ({COUT, SUM} !== 5'b1_1111) begin
            nerr++;
            $display("FAIL async_rst_ignored got=%b exp=%b", {COUT, SUM}, 5'b1_1111);
        end
        @(posedge CLK);
        #1;
        nvec++;
        if ({COUT, SUM} !== 5'b0) begin
            nerr++;
            $display("FAIL midstream_rst got=%b exp=%b", {COUT, SUM}, 5'b0);
        end
        step(4'h9, 4'h8, 1'b1, 1'b1);
        exp_v = sb.pop_front();
        nvec++;
        if ({COUT, SUM} !== exp_v) begin
            nerr++;
            $display("FAIL post_rst got=%b exp=%b", {COUT, SUM}, exp_v);
        end
    endtask

    task automatic test_sweep();
        logic [8:0] v;
        for (int k = 0; k < 512; k++) begin
            v = 9'(k);
            step(v[3:0], v[7:4], v[8], 1'b1);
            exp_v = sb.pop_front();
            nvec++;
            if ({COUT, SUM} !== exp_v) begin
                nerr++;
                $display("FAIL sweep a=%h b=%h cin=%b got=%b exp=%b", v[3:0], v[7:4], v[8], {COUT, SUM}, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] a;
        logic [3:0] b;
        logic       ci;
        logic       rn;
        for (int k = 0; k < 200; k++) begin
            a  = 4'($urandom_range(0, 15));
            b  = 4'($urandom_range(0, 15));
            ci = 1'($urandom_range(0, 1));
            rn = ($urandom_range(0, 9) != 0);
            step(a, b, ci, rn);
            exp_v = sb.pop_front();
            nvec++;
            if ({COUT, SUM} !== exp_v) begin
                nerr++;
                $display("FAIL b2b a=%h b=%h cin=%b rst_n=%b got=%b exp=%b", a, b, ci, rn, {COUT, SUM}, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_midstream();
        test_sweep();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
